// File: rtl/reg_tag_file_pkg.sv
// reg_tag_file_pkg
// Shared definitions for the renaming register/tag file: register count,
// ROB tag encoding, datapath width and the common scalar types.
// No ports; imported by every file of the reg_tag_file slice.
package reg_tag_file_pkg;

   localparam int REG_NUM      = 32;
   localparam int REG_ADDR_W   = 5;
   localparam int INST_TAG_W   = 4;
   localparam int ROB_ENTRIES  = 8;
   localparam int COMMON_WIDTH = 32;
   localparam int CNT_W        = 6;

   typedef logic [COMMON_WIDTH-1:0] data_t;
   typedef logic [INST_TAG_W-1:0]   tag_t;
   typedef logic [REG_ADDR_W-1:0]   reg_addr_t;
   typedef logic [CNT_W-1:0]        cnt_t;

   // Marks a register whose value is final (no producer in flight).
   localparam tag_t TAG_INVALID = 4'd8;

   // A tag names a real ROB entry only when it is below the entry count.
   // TAG_INVALID therefore reads as "no producer / no commit".
   function automatic logic tag_is_live(tag_t t);
      return int'(t) < ROB_ENTRIES;
   endfunction

endpackage

// File: rtl/reg_tag_file_if.sv
// reg_tag_file_if
// Bundles the decode read ports, the rename (alloc) port, the ROB commit
// port, flush and the pending counter.
//   master : decode/ROB side, drives addresses, alloc, commit, flush
//   slave  : the register/tag file, drives read values, tags, pending_cnt
interface reg_tag_file_if;
   import reg_tag_file_pkg::*;

   reg_addr_t rs1_addr;
   reg_addr_t rs2_addr;
   data_t     rs1_val;
   data_t     rs2_val;
   tag_t      rs1_tag;
   tag_t      rs2_tag;

   logic      alloc_en;
   reg_addr_t alloc_rd;
   tag_t      alloc_tag;

   reg_addr_t wb_rd;
   data_t     wb_data;
   tag_t      wb_tag;

   logic      flush;
   cnt_t      pending_cnt;

   modport master (
      output rs1_addr, rs2_addr, alloc_en, alloc_rd, alloc_tag,
             wb_rd, wb_data, wb_tag, flush,
      input  rs1_val, rs2_val, rs1_tag, rs2_tag, pending_cnt
   );

   modport slave (
      input  rs1_addr, rs2_addr, alloc_en, alloc_rd, alloc_tag,
             wb_rd, wb_data, wb_tag, flush,
      output rs1_val, rs2_val, rs1_tag, rs2_tag, pending_cnt
   );

endinterface

// File: rtl/reg_tag_file_read_port.sv
// reg_read_port
// One combinational operand read: array lookup with a same-cycle commit
// bypass so a result retiring this cycle is seen immediately.
//   addr          : source register number
//   vals / tags   : current register values and producer tags
//   wb_rd/data/tag: commit port of this cycle
//   val / tag     : operand value and pending producer tag
module reg_read_port
   import reg_tag_file_pkg::*;
(
   input  reg_addr_t addr,
   input  data_t     vals [REG_NUM],
   input  tag_t      tags [REG_NUM],
   input  reg_addr_t wb_rd,
   input  data_t     wb_data,
   input  tag_t      wb_tag,
   output data_t     val,
   output tag_t      tag
);

   // Register 0 is hardwired. The bypass fires only when the committing
   // tag is still the one this register waits on; a commit of an older
   // producer must not hide a newer pending rename.
   always_comb begin
      val = vals[addr];
      tag = tags[addr];
      if (addr == '0) begin
         val = '0;
         tag = TAG_INVALID;
      end else if (tag_is_live(wb_tag) && wb_rd == addr && tags[addr] == wb_tag) begin
         val = wb_data;
         tag = TAG_INVALID;
      end
   end

endmodule

// File: rtl/reg_tag_file.sv
// reg_tag_file
// Architectural register file with per-register rename tags. Each register
// holds its committed value plus the ROB tag of its youngest in-flight
// producer (TAG_INVALID when final).
//   clk, rst : clock, synchronous active-high reset
//   bus      : reg_tag_file_if.slave (read ports, alloc, commit, flush,
//              pending_cnt)
module reg_tag_file
   import reg_tag_file_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   reg_tag_file_if.slave bus
);

   data_t vals [REG_NUM];
   tag_t  tags [REG_NUM];
   cnt_t  pending_cnt_q;

   logic  wb_commit;
   logic  wb_clear;
   logic  do_alloc;
   logic  alloc_new;
   logic  clear_counted;

   // Decode the events of this cycle. When an allocation and a clearing
   // commit hit the same register the allocation wins, so that clear must
   // not decrement the count (the register stays tagged).
   always_comb begin
      wb_commit     = tag_is_live(bus.wb_tag) && bus.wb_rd != '0;
      wb_clear      = wb_commit && tags[bus.wb_rd] == bus.wb_tag;
      do_alloc      = bus.alloc_en && bus.alloc_rd != '0 && !bus.flush;
      alloc_new     = do_alloc && tags[bus.alloc_rd] == TAG_INVALID;
      clear_counted = wb_clear && !(do_alloc && bus.alloc_rd == bus.wb_rd);
   end

   // State update. Commit data is written even under flush; flush only
   // drops the tags. The allocation write comes after the clear so it
   // takes precedence on a shared rd.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            vals[i] <= '0;
            tags[i] <= TAG_INVALID;
         end
         pending_cnt_q <= '0;
      end else begin
         if (wb_commit)
            vals[bus.wb_rd] <= bus.wb_data;
         if (bus.flush) begin
            for (int i = 0; i < REG_NUM; i++)
               tags[i] <= TAG_INVALID;
            pending_cnt_q <= '0;
         end else begin
            if (wb_clear)
               tags[bus.wb_rd] <= TAG_INVALID;
            if (do_alloc)
               tags[bus.alloc_rd] <= bus.alloc_tag;
            unique case ({alloc_new, clear_counted})
               2'b10: if (pending_cnt_q < cnt_t'(REG_NUM - 1)) pending_cnt_q <= pending_cnt_q + 1'b1;
               2'b01: if (pending_cnt_q != '0) pending_cnt_q <= pending_cnt_q - 1'b1;
               default: pending_cnt_q <= pending_cnt_q;
            endcase
         end
      end
   end

   assign bus.pending_cnt = pending_cnt_q;

   reg_read_port u_rd1 (
      .addr    (bus.rs1_addr),
      .vals    (vals),
      .tags    (tags),
      .wb_rd   (bus.wb_rd),
      .wb_data (bus.wb_data),
      .wb_tag  (bus.wb_tag),
      .val     (bus.rs1_val),
      .tag     (bus.rs1_tag)
   );

   reg_read_port u_rd2 (
      .addr    (bus.rs2_addr),
      .vals    (vals),
      .tags    (tags),
      .wb_rd   (bus.wb_rd),
      .wb_data (bus.wb_data),
      .wb_tag  (bus.wb_tag),
      .val     (bus.rs2_val),
      .tag     (bus.rs2_tag)
   );

endmodule

// File: tb/tb_reg_tag_file.sv
// tb_reg_tag_file
// Directed self-checking bench for reg_tag_file. Inputs change 1 time unit
// after the rising edge; outputs are sampled one further unit later.
module tb_reg_tag_file;
   import reg_tag_file_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   reg_tag_file_if bus ();

   reg_tag_file dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's worth of inputs, then let combinational reads settle.
   task automatic applyStimulus(
      input logic      a_en,
      input reg_addr_t a_rd,
      input tag_t      a_tag,
      input reg_addr_t w_rd,
      input data_t     w_data,
      input tag_t      w_tag,
      input logic      fl,
      input reg_addr_t r1,
      input reg_addr_t r2
   );
      bus.alloc_en  = a_en;
      bus.alloc_rd  = a_rd;
      bus.alloc_tag = a_tag;
      bus.wb_rd     = w_rd;
      bus.wb_data   = w_data;
      bus.wb_tag    = w_tag;
      bus.flush     = fl;
      bus.rs1_addr  = r1;
      bus.rs2_addr  = r2;
      #1;
   endtask

   // Idle cycle: no alloc, no commit, only read addresses.
   task automatic idleRead(input reg_addr_t r1, input reg_addr_t r2);
      applyStimulus(1'b0, 5'd0, 4'd0, 5'd0, 32'h0, TAG_INVALID, 1'b0, r1, r2);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idleRead(5'd5, 5'd0);
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      idleRead(5'd5, 5'd0);
      checkOutput("rst_r5_val", bus.rs1_val, 32'h0);
      checkOutput("rst_r5_tag", 32'(bus.rs1_tag), 32'd8);
      checkOutput("rst_r0_val", bus.rs2_val, 32'h0);
      checkOutput("rst_r0_tag", 32'(bus.rs2_tag), 32'd8);
      checkOutput("rst_cnt", 32'(bus.pending_cnt), 32'd0);

      // Alloc r3 tag 2; same-cycle read must not see the allocation
      applyStimulus(1'b1, 5'd3, 4'd2, 5'd0, 32'h0, TAG_INVALID, 1'b0, 5'd3, 5'd0);
      checkOutput("alloc_same_cycle_tag", 32'(bus.rs1_tag), 32'd8);
      tick();
      idleRead(5'd3, 5'd0);
      checkOutput("r3_tag_after_alloc", 32'(bus.rs1_tag), 32'd2);
      checkOutput("cnt_after_alloc", 32'(bus.pending_cnt), 32'd1);

      // Commit r3 tag 2 -> bypass
      applyStimulus(1'b0, 5'd0, 4'd0, 5'd3, 32'h1234, 4'd2, 1'b0, 5'd3, 5'd0);
      checkOutput("bypass_val", bus.rs1_val, 32'h1234);
      checkOutput("bypass_tag", 32'(bus.rs1_tag), 32'd8);
      tick();
      idleRead(5'd3, 5'd0);
      checkOutput("r3_val_after_commit", bus.rs1_val, 32'h1234);
      checkOutput("r3_tag_after_commit", 32'(bus.rs1_tag), 32'd8);
      checkOutput("cnt_after_commit", 32'(bus.pending_cnt), 32'd0);

      // Re-tag r4 (1 then 5), stale commit of tag 1
      applyStimulus(1'b1, 5'd4, 4'd1, 5'd0, 32'h0, TAG_INVALID, 1'b0, 5'd4, 5'd0);
      tick();
      applyStimulus(1'b1, 5'd4, 4'd5, 5'd0, 32'h0, TAG_INVALID, 1'b0, 5'd4, 5'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 4'd0, 5'd4, 32'hAA, 4'd1, 1'b0, 5'd4, 5'd0);
      checkOutput("stale_no_bypass_val", bus.rs1_val, 32'h0);
      checkOutput("stale_no_bypass_tag", 32'(bus.rs1_tag), 32'd5);
      tick();
      idleRead(5'd4, 5'd0);
      checkOutput("r4_val", bus.rs1_val, 32'hAA);
      checkOutput("r4_tag_kept", 32'(bus.rs1_tag), 32'd5);
      checkOutput("cnt_retag", 32'(bus.pending_cnt), 32'd1);

      // r7 tagged 3, then alloc tag 6 with commit tag 3 in the same cycle
      applyStimulus(1'b1, 5'd7, 4'd3, 5'd0, 32'h0, TAG_INVALID, 1'b0, 5'd7, 5'd0);
      tick();
      idleRead(5'd7, 5'd0);
      checkOutput("cnt_r7_alloc", 32'(bus.pending_cnt), 32'd2);
      applyStimulus(1'b1, 5'd7, 4'd6, 5'd7, 32'h55, 4'd3, 1'b0, 5'd7, 5'd0);
      checkOutput("r7_bypass_val", bus.rs1_val, 32'h55);
      checkOutput("r7_bypass_tag", 32'(bus.rs1_tag), 32'd8);
      tick();
      idleRead(5'd7, 5'd0);
      checkOutput("r7_val", bus.rs1_val, 32'h55);
      checkOutput("r7_tag_alloc_wins", 32'(bus.rs1_tag), 32'd6);
      checkOutput("cnt_clear_plus_alloc", 32'(bus.pending_cnt), 32'd2);

      // Alloc r1, r2, r9 then flush with alloc r10 and a commit to r9
      applyStimulus(1'b1, 5'd1, 4'd0, 5'd0, 32'h0, TAG_INVALID, 1'b0, 5'd1, 5'd0);
      tick();
      applyStimulus(1'b1, 5'd2, 4'd1, 5'd0, 32'h0, TAG_INVALID, 1'b0, 5'd2, 5'd0);
      tick();
      applyStimulus(1'b1, 5'd9, 4'd2, 5'd0, 32'h0, TAG_INVALID, 1'b0, 5'd9, 5'd0);
      tick();
      idleRead(5'd1, 5'd9);
      checkOutput("cnt_before_flush", 32'(bus.pending_cnt), 32'd5);
      applyStimulus(1'b1, 5'd10, 4'd3, 5'd9, 32'h99, 4'd2, 1'b1, 5'd10, 5'd9);
      tick();
      idleRead(5'd10, 5'd9);
      checkOutput("flush_r10_tag", 32'(bus.rs1_tag), 32'd8);
      checkOutput("flush_r9_tag", 32'(bus.rs2_tag), 32'd8);
      checkOutput("flush_r9_val", bus.rs2_val, 32'h99);
      checkOutput("flush_cnt", 32'(bus.pending_cnt), 32'd0);
      idleRead(5'd1, 5'd7);
      checkOutput("flush_r1_tag", 32'(bus.rs1_tag), 32'd8);
      checkOutput("flush_r7_tag", 32'(bus.rs2_tag), 32'd8);

      // Register 0 ignores alloc and commit
      applyStimulus(1'b1, 5'd0, 4'd4, 5'd0, 32'hFFFF, 4'd4, 1'b0, 5'd0, 5'd0);
      checkOutput("r0_same_cycle_val", bus.rs1_val, 32'h0);
      tick();
      idleRead(5'd0, 5'd0);
      checkOutput("r0_val", bus.rs1_val, 32'h0);
      checkOutput("r0_tag", 32'(bus.rs1_tag), 32'd8);
      checkOutput("r0_cnt", 32'(bus.pending_cnt), 32'd0);

      // Commit carrying TAG_INVALID writes nothing
      applyStimulus(1'b0, 5'd0, 4'd0, 5'd12, 32'hDEAD, TAG_INVALID, 1'b0, 5'd12, 5'd0);
      tick();
      idleRead(5'd12, 5'd0);
      checkOutput("no_commit_r12_val", bus.rs1_val, 32'h0);

      // Fill every register: count tops out at 31, re-tag does not move it
      for (int i = 1; i < 32; i++) begin
         applyStimulus(1'b1, 5'(i), 4'(i % 8), 5'd0, 32'h0, TAG_INVALID, 1'b0, 5'd0, 5'd0);
         tick();
      end
      idleRead(5'd31, 5'd5);
      checkOutput("cnt_full", 32'(bus.pending_cnt), 32'd31);
      checkOutput("r31_tag", 32'(bus.rs1_tag), 32'd7);
      applyStimulus(1'b1, 5'd1, 4'd7, 5'd0, 32'h0, TAG_INVALID, 1'b0, 5'd0, 5'd0);
      tick();
      idleRead(5'd1, 5'd5);
      checkOutput("cnt_full_retag", 32'(bus.pending_cnt), 32'd31);
      applyStimulus(1'b0, 5'd0, 4'd0, 5'd5, 32'h5A5A, 4'd5, 1'b0, 5'd5, 5'd0);
      tick();
      idleRead(5'd5, 5'd0);
      checkOutput("cnt_after_clear", 32'(bus.pending_cnt), 32'd30);
      checkOutput("r5_val", bus.rs1_val, 32'h5A5A);

      // Reset mid-operation overrides alloc and commit
      rst = 1'b1;
      applyStimulus(1'b1, 5'd6, 4'd1, 5'd8, 32'h77, 4'd0, 1'b0, 5'd8, 5'd6);
      tick();
      rst = 1'b0;
      idleRead(5'd8, 5'd6);
      checkOutput("mid_rst_r8_val", bus.rs1_val, 32'h0);
      checkOutput("mid_rst_r8_tag", 32'(bus.rs1_tag), 32'd8);
      checkOutput("mid_rst_r6_tag", 32'(bus.rs2_tag), 32'd8);
      checkOutput("mid_rst_cnt", 32'(bus.pending_cnt), 32'd0);
      idleRead(5'd5, 5'd3);
      checkOutput("mid_rst_r5_val", bus.rs1_val, 32'h0);
      checkOutput("mid_rst_r3_val", bus.rs2_val, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
